mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 203 ++++++++++++++++++++
 tb/tb_mem_lsu.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit bridging EXE requests to an sram-like data port.
// Optional build macro LSU_MISALIGN_EXC_EN: misaligned accesses raise out_adel/out_ades instead of being force-aligned.

module mem_lsu #(
    parameter int          DATA_W    = 32,
    parameter logic [31:0] ADDR_MASK = 32'h1fffffff
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_load,
    input  logic              in_store,
    input  logic              in_unsigned,
    input  logic [1:0]        in_size,
    input  logic [31:0]       in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              cancel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_adel,
    output logic              out_ades,
    output logic [31:0]       out_badvaddr,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [31:0]       data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok
);

    localparam int OFF_W = (DATA_W == 64) ? 3 : 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_HOLD
    } state_t;

    typedef struct packed {
        logic             load;
        logic             store;
        logic             uns;
        logic [1:0]       size;
        logic [OFF_W-1:0] off;
    } ctx_t;

    state_t            state_q;
    ctx_t              ctx_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_rdata_q;
    logic              data_req_q;
    logic              data_wr_q;
    logic [1:0]        data_size_q;
    logic [31:0]       data_addr_q;
    logic [DATA_W-1:0] data_wdata_q;

    logic [1:0]        in_esize;
    logic [31:0]       align_msk;
    logic [31:0]       in_aligned;
    logic [OFF_W-1:0]  in_off;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] ld_sh;
    logic [DATA_W-1:0] ld_res;

    // A dword on a 32-bit path degrades to a word; alignment always follows the effective size.
    always_comb begin
        in_esize   = (in_size == 2'd3 && DATA_W == 32) ? 2'd2 : in_size;
        align_msk  = ~((32'd1 << in_esize) - 32'd1);
        in_aligned = in_addr & align_msk;
        in_off     = in_aligned[OFF_W-1:0];
        wdata_sh   = in_wdata << {in_off, 3'b000};
    end

    always_comb begin
        ld_sh  = data_rdata >> {ctx_q.off, 3'b000};
        ld_res = ld_sh;
        case (ctx_q.size)
            2'd0:    ld_res = ctx_q.uns ? DATA_W'(ld_sh[7:0])  : DATA_W'($signed(ld_sh[7:0]));
            2'd1:    ld_res = ctx_q.uns ? DATA_W'(ld_sh[15:0]) : DATA_W'($signed(ld_sh[15:0]));
            2'd2:    ld_res = ctx_q.uns ? DATA_W'(ld_sh[31:0]) : DATA_W'($signed(ld_sh[31:0]));
            default: ld_res = ld_sh;
        endcase
    end

`ifdef LSU_MISALIGN_EXC_EN
    logic        in_mis;
    logic        adel_q;
    logic        ades_q;
    logic [31:0] badvaddr_q;

    assign in_mis       = |(in_addr & ~align_msk);
    assign out_adel     = adel_q;
    assign out_ades     = ades_q;
    assign out_badvaddr = badvaddr_q;
`else
    assign out_adel     = 1'b0;
    assign out_ades     = 1'b0;
    assign out_badvaddr = 32'd0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            ctx_q        <= '0;
            out_valid_q  <= 1'b0;
            out_rdata_q  <= '0;
            data_req_q   <= 1'b0;
            data_wr_q    <= 1'b0;
            data_size_q  <= 2'd0;
            data_addr_q  <= 32'd0;
            data_wdata_q <= '0;
`ifdef LSU_MISALIGN_EXC_EN
            adel_q       <= 1'b0;
            ades_q       <= 1'b0;
            badvaddr_q   <= 32'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && !cancel) begin
                        ctx_q.load   <= in_load;
                        ctx_q.store  <= in_store;
                        ctx_q.uns    <= in_unsigned;
                        ctx_q.size   <= in_esize;
                        ctx_q.off    <= in_off;
                        out_rdata_q  <= '0;
                        data_wr_q    <= in_store;
                        data_size_q  <= in_esize;
                        data_addr_q  <= in_aligned & ADDR_MASK;
                        data_wdata_q <= wdata_sh;
`ifdef LSU_MISALIGN_EXC_EN
                        adel_q       <= 1'b0;
                        ades_q       <= 1'b0;
                        badvaddr_q   <= 32'd0;
`endif
                        if (!(in_load || in_store)) begin
                            state_q     <= S_HOLD;
                            out_valid_q <= 1'b1;
`ifdef LSU_MISALIGN_EXC_EN
                        end else if (in_mis) begin
                            state_q     <= S_HOLD;
                            out_valid_q <= 1'b1;
                            adel_q      <= in_load;
                            ades_q      <= in_store & ~in_load;
                            badvaddr_q  <= in_addr;
`endif
                        end else begin
                            state_q    <= S_REQ;
                            data_req_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    // A request already taken by the port must still have its response drained.
                    if (cancel) begin
                        data_req_q <= 1'b0;
                        state_q    <= data_addr_ok ? S_DRAIN : S_IDLE;
                    end else if (data_addr_ok) begin
                        data_req_q <= 1'b0;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cancel) begin
                        state_q <= data_data_ok ? S_IDLE : S_DRAIN;
                    end else if (data_data_ok) begin
                        state_q     <= S_HOLD;
                        out_valid_q <= 1'b1;
                        out_rdata_q <= (ctx_q.load && !ctx_q.store) ? ld_res : '0;
                    end
                end
                S_DRAIN: begin
                    if (data_data_ok) begin
                        state_q <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (cancel || out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == S_IDLE) && !cancel;
    assign out_valid  = out_valid_q;
    assign out_rdata  = out_rdata_q;
    assign data_req   = data_req_q;
    assign data_wr    = data_wr_q;
    assign data_size  = data_size_q;
    assign data_addr  = data_addr_q;
    assign data_wdata = data_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed cycle-exact cases, then random traffic against a byte-level memory model.

module tb_mem_lsu;

    localparam int          DW   = 32;
    localparam logic [31:0] MASK = 32'h1fffffff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic          in_valid, in_ready, in_load, in_store, in_unsigned;
    logic [1:0]    in_size;
    logic [31:0]   in_addr;
    logic [DW-1:0] in_wdata;
    logic          cancel;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_rdata;
    logic          out_adel, out_ades;
    logic [31:0]   out_badvaddr;
    logic          data_req, data_wr;
    logic [1:0]    data_size;
    logic [31:0]   data_addr;
    logic [DW-1:0] data_wdata, data_rdata;
    logic          data_addr_ok, data_data_ok;

    logic          slave_en;
    logic          s_aok, s_dok, m_aok, m_dok, r_ordy, m_ordy;
    logic [DW-1:0] s_rdata, m_rdata;

    assign data_addr_ok = slave_en ? s_aok   : m_aok;
    assign data_data_ok = slave_en ? s_dok   : m_dok;
    assign data_rdata   = slave_en ? s_rdata : m_rdata;
    assign out_ready    = slave_en ? r_ordy  : m_ordy;

    mem_lsu #(.DATA_W(DW), .ADDR_MASK(MASK)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
        .in_unsigned(in_unsigned), .in_size(in_size), .in_addr(in_addr), .in_wdata(in_wdata),
        .cancel(cancel),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_adel(out_adel), .out_ades(out_ades), .out_badvaddr(out_badvaddr),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
    );

    // 64-bit instance for the wide-path lane and size cases
    logic        w_in_valid, w_in_ready, w_in_load, w_in_store, w_in_unsigned, w_cancel;
    logic [1:0]  w_in_size, w_data_size;
    logic [31:0] w_in_addr, w_badvaddr, w_data_addr;
    logic [63:0] w_in_wdata, w_out_rdata, w_data_wdata, w_data_rdata;
    logic        w_out_valid, w_out_ready, w_adel, w_ades, w_data_req, w_data_wr, w_aok, w_dok;

    mem_lsu #(.DATA_W(64), .ADDR_MASK(MASK)) dut64 (
        .clk(clk), .resetn(resetn),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_load(w_in_load), .in_store(w_in_store),
        .in_unsigned(w_in_unsigned), .in_size(w_in_size), .in_addr(w_in_addr), .in_wdata(w_in_wdata),
        .cancel(w_cancel),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_rdata(w_out_rdata),
        .out_adel(w_adel), .out_ades(w_ades), .out_badvaddr(w_badvaddr),
        .data_req(w_data_req), .data_wr(w_data_wr), .data_size(w_data_size), .data_addr(w_data_addr),
        .data_wdata(w_data_wdata), .data_rdata(w_data_rdata),
        .data_addr_ok(w_aok), .data_data_ok(w_dok)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_e;

    typedef struct {
        logic [31:0] rdata;
        logic        adel;
        logic        ades;
        logic [31:0] bad;
    } rsp_e;

    req_e req_q[$];
    rsp_e rsp_q[$];
    logic [7:0] mmem[64];
    logic [7:0] smem[64];

    // Random sram slave: owns s_*, applies stores to its own byte array, checks issued request fields
    int          s_pend = 0;
    int          s_cnt  = 0;
    logic [31:0] s_paddr;
    logic        s_held = 1'b0;
    logic [67:0] s_prev;

    initial begin
        s_aok = 1'b0; s_dok = 1'b0; s_rdata = '0; s_paddr = '0; s_prev = '0;
        forever begin
            @(negedge clk);
            if (slave_en && resetn) begin
                if (s_held)
                    chk("req_stable", {67'd0, {data_req, data_wr, data_size, data_addr, data_wdata} == s_prev}, 64'd1);
                s_held = data_req && !data_addr_ok;
                s_prev = {data_req, data_wr, data_size, data_addr, data_wdata};
                if (s_dok) s_pend = 0;
                if (data_req && data_addr_ok) begin
                    if (req_q.size() == 0) begin
                        chk("req_unexpected", 64'd1, 64'd0);
                    end else begin
                        req_e e;
                        e = req_q.pop_front();
                        chk("req_wr", data_wr, e.wr);
                        chk("req_size", data_size, e.size);
                        chk("req_addr", data_addr, e.addr);
                        if (e.wr) chk("req_wdata", data_wdata, e.wdata);
                    end
                    if (data_wr) begin
                        for (int i = 0; i < (1 << data_size); i++) begin
                            int lane;
                            lane = int'(data_addr[1:0]) + i;
                            if (lane < 4) smem[(int'(data_addr[5:2]) * 4 + lane) % 64] = data_wdata[8*lane +: 8];
                        end
                    end
                    s_pend  = 1;
                    s_cnt   = $urandom_range(1, 3);
                    s_paddr = data_addr;
                end
            end
            @(posedge clk);
            #1;
            s_aok   = ($urandom_range(0, 1) == 1);
            s_dok   = 1'b0;
            s_rdata = $urandom;
            if (s_pend != 0) begin
                s_cnt--;
                if (s_cnt == 0) begin
                    int b;
                    b = int'(s_paddr[5:2]) * 4;
                    s_dok   = 1'b1;
                    s_rdata = {smem[b+3], smem[b+2], smem[b+1], smem[b]};
                end
            end
        end
    end

    initial begin
        r_ordy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            r_ordy = ($urandom_range(0, 3) != 0);
        end
    end

    // Response monitor: pops the scoreboard on every completed output handshake
    logic        m_held = 1'b0;
    logic [31:0] m_prev = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (slave_en && resetn) begin
                if (m_held) begin
                    chk("hold_valid", out_valid, 1'b1);
                    chk("hold_rdata", out_rdata, m_prev);
                end
                m_held = out_valid && !out_ready;
                m_prev = out_rdata;
                if (out_valid && out_ready) begin
                    if (rsp_q.size() == 0) begin
                        chk("rsp_unexpected", 64'd1, 64'd0);
                    end else begin
                        rsp_e r;
                        r = rsp_q.pop_front();
                        chk("rsp_rdata", out_rdata, r.rdata);
                        chk("rsp_adel", out_adel, r.adel);
                        chk("rsp_ades", out_ades, r.ades);
                        chk("rsp_badvaddr", out_badvaddr, r.bad);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic l, input logic s, input logic u, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        in_load = l; in_store = s; in_unsigned = u; in_size = sz; in_addr = a; in_wdata = wd;
        in_valid = 1'b1;
        @(negedge clk);
        chk("accept_ready", in_ready, 1'b1);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic xact(input string nm, input logic l, input logic s, input logic u, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [31:0] e_rdata);
        issue(l, s, u, sz, a, wd);
        m_aok = 1'b1;
        @(negedge clk);
        chk({nm, "_req"}, data_req, 1'b1);
        chk({nm, "_addr"}, data_addr, e_addr);
        chk({nm, "_size"}, data_size, sz);
        chk({nm, "_wr"}, data_wr, s);
        if (s) chk({nm, "_wdata"}, data_wdata, e_wdata);
        cyc();
        m_aok = 1'b0; m_dok = 1'b1; m_rdata = rd;
        @(negedge clk);
        chk({nm, "_early_valid"}, out_valid, 1'b0);
        cyc();
        m_dok = 1'b0; m_rdata = '0;
        @(negedge clk);
        chk({nm, "_valid"}, out_valid, 1'b1);
        chk({nm, "_rdata"}, out_rdata, e_rdata);
        m_ordy = 1'b1;
        cyc();
        m_ordy = 1'b0;
        @(negedge clk);
        chk({nm, "_done"}, out_valid, 1'b0);
        cyc();
    endtask

    task automatic wxact(input string nm, input logic [1:0] sz, input logic [31:0] a, input logic [63:0] rd,
                         input logic [31:0] e_addr, input logic [63:0] e_rdata);
        w_in_load = 1'b1; w_in_store = 1'b0; w_in_unsigned = 1'b0; w_in_size = sz; w_in_addr = a;
        w_in_valid = 1'b1;
        @(negedge clk);
        chk({nm, "_ready"}, w_in_ready, 1'b1);
        cyc();
        w_in_valid = 1'b0; w_aok = 1'b1;
        @(negedge clk);
        chk({nm, "_req"}, w_data_req, 1'b1);
        chk({nm, "_size"}, w_data_size, sz);
        chk({nm, "_addr"}, w_data_addr, e_addr);
        cyc();
        w_aok = 1'b0; w_dok = 1'b1; w_data_rdata = rd;
        cyc();
        w_dok = 1'b0;
        @(negedge clk);
        chk({nm, "_valid"}, w_out_valid, 1'b1);
        chk({nm, "_rdata"}, w_out_rdata, e_rdata);
        w_out_ready = 1'b1;
        cyc();
        w_out_ready = 1'b0;
    endtask

    // Reference: byte-addressed memory, little-endian, natural alignment by access size
    task automatic model_accept(input logic l, input logic s, input logic u, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] wd);
        int          nb;
        logic [31:0] ea;
        logic [63:0] v;
        rsp_e        r;
        req_e        q;
        nb = (sz == 2'd3) ? 4 : (1 << sz);
        ea = (a & MASK) & ~(32'(nb) - 32'd1);
        r.rdata = '0; r.adel = 1'b0; r.ades = 1'b0; r.bad = '0;
        if (l || s) begin
`ifdef LSU_MISALIGN_EXC_EN
            if ((a % nb) != 0) begin
                r.adel = l; r.ades = s && !l; r.bad = a;
                rsp_q.push_back(r);
                return;
            end
`endif
            q.wr = s; q.size = 2'(nb / 2 + nb / 4 - nb / 8 * 0 - (nb == 4 ? 1 : 0)); q.addr = ea;
            q.size = (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
            q.wdata = wd << (8 * int'(ea[1:0]));
            req_q.push_back(q);
            if (s) begin
                for (int i = 0; i < nb; i++) mmem[(int'(ea) + i) % 64] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < nb; i++) v = v | (64'(mmem[(int'(ea) + i) % 64]) << (8 * i));
                if (!u && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
                r.rdata = v[31:0];
            end
        end
        rsp_q.push_back(r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; slave_en = 1'b0; cancel = 1'b0;
        in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_unsigned = 1'b0; in_size = 2'd0;
        in_addr = '0; in_wdata = '0;
        m_aok = 1'b0; m_dok = 1'b0; m_rdata = '0; m_ordy = 1'b0;
        w_in_valid = 1'b0; w_in_load = 1'b0; w_in_store = 1'b0; w_in_unsigned = 1'b0; w_cancel = 1'b0;
        w_in_size = 2'd0; w_in_addr = '0; w_in_wdata = '0; w_out_ready = 1'b0;
        w_aok = 1'b0; w_dok = 1'b0; w_data_rdata = '0;
        for (int i = 0; i < 64; i++) begin
            mmem[i] = 8'($urandom);
            smem[i] = mmem[i];
        end

        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_rdata", out_rdata, '0);
        chk("rst_data_req", data_req, 1'b0);
        chk("rst_data_wr", data_wr, 1'b0);
        chk("rst_exc", {out_adel, out_ades, out_badvaddr}, '0);
        cyc();
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_ready", in_ready, 1'b1);
        cyc();

        xact("lw", 1, 0, 0, 2'd2, 32'h80000004, 0, 32'h12345678, 32'h00000004, 0, 32'h12345678);
        xact("lb", 1, 0, 0, 2'd0, 32'h80000003, 0, 32'h80FFFFFF, 32'h00000003, 0, 32'hFFFFFF80);
        xact("lbu", 1, 0, 1, 2'd0, 32'h80000003, 0, 32'h80FFFFFF, 32'h00000003, 0, 32'h00000080);
        xact("lhs", 1, 0, 0, 2'd1, 32'hA0000012, 0, 32'h9ABC1234, 32'h00000012, 0, 32'hFFFF9ABC);
        xact("sh", 0, 1, 0, 2'd1, 32'h80000002, 32'h0000BEEF, 32'h55555555, 32'h00000002, 32'hBEEF0000, 0);
        xact("sb", 0, 1, 0, 2'd0, 32'h80000001, 32'h000000A5, 32'h0, 32'h00000001, 32'h0000A500, 0);

`ifdef LSU_MISALIGN_EXC_EN
        issue(1, 0, 0, 2'd2, 32'h80000002, 0);
        @(negedge clk);
        chk("mis_req", data_req, 1'b0);
        chk("mis_valid", out_valid, 1'b1);
        chk("mis_adel", out_adel, 1'b1);
        chk("mis_ades", out_ades, 1'b0);
        chk("mis_badvaddr", out_badvaddr, 32'h80000002);
        m_ordy = 1'b1;
        cyc();
        m_ordy = 1'b0;
`else
        xact("mis_lw", 1, 0, 0, 2'd2, 32'h80000006, 0, 32'hCAFEF00D, 32'h00000004, 0, 32'hCAFEF00D);
        chk("mis_exc", {out_adel, out_ades, out_badvaddr}, '0);
`endif

        // cancel while waiting for data: drain the response, never present it
        issue(1, 0, 0, 2'd2, 32'h80000008, 0);
        m_aok = 1'b1;
        cyc();
        m_aok = 1'b0; cancel = 1'b1;
        @(negedge clk);
        chk("cw_ready_blocked", in_ready, 1'b0);
        cyc();
        cancel = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("cw_drain_ready", in_ready, 1'b0);
            chk("cw_drain_req", data_req, 1'b0);
            cyc();
        end
        m_dok = 1'b1; m_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("cw_dok_ready", in_ready, 1'b0);
        cyc();
        m_dok = 1'b0;
        @(negedge clk);
        chk("cw_after_ready", in_ready, 1'b1);
        chk("cw_after_valid", out_valid, 1'b0);
        cyc();

        // cancel in REQ without address acceptance
        issue(1, 0, 0, 2'd2, 32'h8000000C, 0);
        cancel = 1'b1;
        @(negedge clk);
        chk("cr_req", data_req, 1'b1);
        cyc();
        cancel = 1'b0;
        @(negedge clk);
        chk("cr_req_gone", data_req, 1'b0);
        chk("cr_ready", in_ready, 1'b1);
        cyc();

        // cancel in REQ coinciding with address acceptance
        issue(0, 1, 0, 2'd2, 32'h80000010, 32'h11112222);
        cancel = 1'b1; m_aok = 1'b1;
        cyc();
        cancel = 1'b0; m_aok = 1'b0;
        @(negedge clk);
        chk("cra_drain_ready", in_ready, 1'b0);
        chk("cra_drain_req", data_req, 1'b0);
        cyc();
        m_dok = 1'b1;
        cyc();
        m_dok = 1'b0;
        @(negedge clk);
        chk("cra_ready", in_ready, 1'b1);
        chk("cra_valid", out_valid, 1'b0);
        cyc();

        // neither load nor store, held then cancelled in HOLD
        issue(0, 0, 0, 2'd2, 32'h80000020, 32'hFFFFFFFF);
        @(negedge clk);
        chk("nop_valid", out_valid, 1'b1);
        chk("nop_rdata", out_rdata, '0);
        chk("nop_req", data_req, 1'b0);
        cyc();
        @(negedge clk);
        chk("nop_hold", out_valid, 1'b1);
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        @(negedge clk);
        chk("ch_valid", out_valid, 1'b0);
        chk("ch_ready", in_ready, 1'b1);
        cyc();

        // cancel in IDLE blocks acceptance
        cancel = 1'b1; in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_size = 2'd2; in_addr = 32'h80000024;
        @(negedge clk);
        chk("ci_ready", in_ready, 1'b0);
        cyc();
        cancel = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("ci_req", data_req, 1'b0);
        cyc();

        // asynchronous reset while waiting; the late data_ok must be ignored
        issue(1, 0, 0, 2'd2, 32'h80000028, 0);
        m_aok = 1'b1;
        cyc();
        m_aok = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("ra_req", data_req, 1'b0);
        chk("ra_ready", in_ready, 1'b1);
        cyc();
        resetn = 1'b1; m_dok = 1'b1; m_rdata = 32'h13572468;
        cyc();
        m_dok = 1'b0;
        @(negedge clk);
        chk("ra_valid", out_valid, 1'b0);
        chk("ra_rdata", out_rdata, '0);
        cyc();

        wxact("ld64", 2'd3, 32'h80000008, 64'h0123456789ABCDEF, 32'h00000008, 64'h0123456789ABCDEF);
        wxact("lw64", 2'd2, 32'h80000004, 64'hAABBCCDD00000000, 32'h00000004, 64'hFFFFFFFFAABBCCDD);

        // random traffic against the scoreboard
        slave_en = 1'b1;
        for (int t = 0; t < 300; t++) begin
            int          op;
            int          w;
            logic        l, s, u;
            logic [1:0]  sz;
            logic [31:0] a, wd;
            op = $urandom_range(0, 5);
            l  = (op <= 2);
            s  = (op == 3 || op == 4);
            u  = ($urandom_range(0, 1) == 1);
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom & 32'hE0000000) | 32'($urandom_range(0, 63));
            wd = $urandom;
            in_load = l; in_store = s; in_unsigned = u; in_size = sz; in_addr = a; in_wdata = wd;
            in_valid = 1'b1;
            w = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                w++;
                if (w > 100) break;
                cyc();
            end
            if (w > 100) begin
                chk("accept_timeout", 64'd1, 64'd0);
                in_valid = 1'b0;
                break;
            end
            model_accept(l, s, u, sz, a, wd);
            cyc();
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) cyc();
        end
        for (int i = 0; i < 200 && rsp_q.size() != 0; i++) cyc();
        chk("rsp_drained", rsp_q.size(), 0);
        chk("req_drained", req_q.size(), 0);
        slave_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
